wrr_fifo_scheduler: RTL and testbench
=====================================

# wrr_fifo_scheduler

Weighted round-robin read scheduler for the four per-port input FIFOs of the round-robin FIFO arbiter datapath. It watches the FIFO non-empty flags and issues one-hot read enables, so that a port keeps ownership of the output for up to its configured weight of reads. Ownership then rotates to the next eligible port. It sits between the FIFO bank and the output register, and it honours downstream backpressure.

## Interface
- `N_REQ`, 4, number of requesters (FIFOs); the design is fixed at 4.
- `WEIGHT_W`, 3, width of the per-port weight and credit counter.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  4  `req[i]` = 1 when FIFO i is non-empty.
- `out_ready`  in  1  downstream accepts a word this cycle.
- `cfg_we`  in  1  write strobe for the weight table.
- `cfg_id`  in  2  port index for the weight write.
- `cfg_weight`  in  WEIGHT_W  new weight for port `cfg_id`.
- `ren`  out  4  one-hot read enable to FIFO i; combinational.
- `gnt_id`  out  2  index of the current owner (registered).
- `gnt_valid`  out  1  equals `|ren`.
- `busy`  out  1  high while the FSM is in SERVE.

## Operation
- **Reset values:** state IDLE; `ptr` = 0; `owner` = 0; `credit` = 0; all weights = 1; `ren` = 0; `gnt_id` = 0; `gnt_valid` = 0; `busy` = 0.
- **Eligible set:** `elig[i] = req[i] & (weight[i] != 0)`. A port with weight 0 is never served.
- **Pick rule:** choose the first eligible index searching cyclically from a start index (start, start+1, ... modulo 4).
- **IDLE state:**
  - If `elig` is non-zero: `owner` ← pick(start = `ptr`), `credit` ← `weight[owner]`, go to SERVE.
  - Otherwise remain in IDLE.
  - `ren` = 0 throughout IDLE.
- **SERVE state:**
  - `ren[owner] = req[owner] & out_ready`. Each ren cycle decrements `credit`.
- **Release from SERVE** happens when either condition holds:
  - (a) a ren occurs with `credit` == 1; or
  - (b) `req[owner]` == 0.
- **On release:**
  - `ptr` ← `owner`+1 (mod 4).
  - If `elig` (masked by `req`) is non-zero, load the new owner directly: pick(start = `owner`+1), load its credit, and stay in SERVE. There is no bubble cycle.
  - Otherwise go to IDLE.
- **Wrap-back to same owner:** the pick may wrap back to the same owner. If its FIFO empties on the following cycle, rule (b) releases it with no ren issued.
- **Backpressure:** `out_ready` = 0 holds all state; `credit` is not consumed.
- **Weight writes:** when `cfg_we` is high, `weight[cfg_id]` ← `cfg_weight`. A new weight takes effect at that port's next credit load. A write in the same cycle as a load does not affect that load; the old value is used.
- **Arithmetic:** `credit` is unsigned, WEIGHT_W bits. It never underflows, because release occurs at 1.

## Timing
- **Grant latency:** `req` rising while IDLE gives `ren` no earlier than the next cycle.
- **Read response:** FIFO data is valid the cycle after `ren` (FIFO read latency, outside this block).
- **Switch between owners:** zero idle cycles, provided another port is eligible at release.
- **Reset dominance:** `rst` dominates `cfg_we` and all other inputs. Reset mid-burst drops ownership immediately; `ren` is 0 in the cycle after `rst` is sampled.
- **Combinational paths:** `ren` and `gnt_valid` depend on `req` and `out_ready`. No other combinational input-to-output paths exist.

## Configuration
- **Macro:** `WRR_WEIGHTS_EN`.
- **Defined:** the weight table, the cfg write path and weight-0 masking are present, as described above.
- **Undefined:**
  - The `cfg_*` ports exist but are ignored.
  - Every credit load is 1 and `elig` = `req`, giving plain one-read-per-turn round-robin.
  - The weight registers are not synthesized.

## Structure
- **Package `wrr_pkg`:** `N_REQ`, `ID_W` = 2, `WEIGHT_W` default, and the state type {IDLE, SERVE}.
- **Sub-module `rr_pick`:** combinational cyclic priority search. Inputs are a 4-bit mask and a 2-bit start index; outputs are `found` and a 2-bit index. It is instantiated twice: once for start = `ptr` and once for start = `owner`+1.

## Test plan
- **Plain round-robin:** reset, weights = 1, `req` = 1111 held, `out_ready` = 1 → `ren` sequence 0001, 0010, 0100, 1000, 0001, starting the cycle after reset release.
- **Weighted burst:** weights {a=3, b=1, c=2, d=1}, `req` = 1111 held → `ren` repeats a, a, a, b, c, c, d with no gaps.
- **Early empty:** port a (weight 4) holds 2 words while only b requests → two a-reads, then release on `req[0]` = 0, then b is served; `gnt_id` 0 → 1.
- **Backpressure:** `out_ready` low for 3 cycles mid-burst on port c with credit 2 → `ren` = 0 for those cycles; then exactly 2 c-reads follow.
- **Weight-0 mask and reset priority:** write weight[b] = 0 with `req` = 0010 → stays in IDLE, `ren` = 0. Assert `rst` mid-SERVE → next cycle state IDLE, `ptr` = 0, all weights = 1.
- **Macro undefined:** same stimulus as the weighted-burst case → plain round-robin sequence 0001, 0010, 0100, 1000; cfg writes have no effect.

Source files
------------

// File: rtl/wrr_pkg.sv
// Shared constants and types for the weighted round-robin FIFO read scheduler.
package wrr_pkg;

    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int WEIGHT_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority search: returns the first set bit of mask, scanning
// start, start+1, ... modulo N_REQ. Purely combinational.
module rr_pick
    import wrr_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [ID_W-1:0]  start,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    // mask rotated so that bit 0 corresponds to the start index
    logic [N_REQ-1:0] rot;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [ID_W-1:0] src;
            assign src     = start + ID_W'(gi);
            assign rot[gi] = mask[src];
        end
    endgenerate

    // lowest set bit of the rotated mask, mapped back to an absolute index
    always_comb begin
        found = |rot;
        idx   = start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = start + ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/wrr_fifo_scheduler.sv
// Weighted round-robin read scheduler for four input FIFOs.
// A port keeps the output for up to weight[i] reads, then ownership rotates
// to the next eligible port with no bubble cycle. out_ready low freezes the
// scheduler. Build option WRR_WEIGHTS_EN enables the programmable weight
// table (with weight-0 masking); without it every turn is a single read and
// the cfg_* ports are ignored.
module wrr_fifo_scheduler
    import wrr_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic                out_ready,
    input  logic                cfg_we,
    input  logic [ID_W-1:0]     cfg_id,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    output logic [N_REQ-1:0]    ren,
    output logic [ID_W-1:0]     gnt_id,
    output logic                gnt_valid,
    output logic                busy
);

    state_t                          state_reg;
    logic [ID_W-1:0]                 ptr_reg;
    logic [ID_W-1:0]                 owner_reg;
    logic [WEIGHT_W-1:0]             credit_reg;

    logic [N_REQ-1:0]                elig;
    logic [N_REQ-1:0][WEIGHT_W-1:0]  weight_eff;

    logic                            idle_found;
    logic [ID_W-1:0]                 idle_idx;
    logic                            next_found;
    logic [ID_W-1:0]                 next_idx;
    logic [ID_W-1:0]                 owner_inc;
    logic                            rd_fire;
    logic                            release_now;

`ifdef WRR_WEIGHTS_EN
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_weight
            logic [WEIGHT_W-1:0] weight_reg;

            // per-port weight register; reset restores the default of one read per turn
            always_ff @(posedge clk) begin
                if (rst) begin
                    weight_reg <= WEIGHT_W'(1);
                end else if (cfg_we && (cfg_id == ID_W'(gi))) begin
                    weight_reg <= cfg_weight;
                end
            end

            assign weight_eff[gi] = weight_reg;
            assign elig[gi]       = req[gi] & (weight_reg != '0);
        end
    endgenerate
`else
    // configuration path is absent: fold the ports into a dead signal
    logic cfg_unused;
    assign cfg_unused = ^{cfg_we, cfg_id, cfg_weight};

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_weight
            assign weight_eff[gi] = WEIGHT_W'(1);
            assign elig[gi]       = req[gi];
        end
    endgenerate
`endif

    assign owner_inc = owner_reg + ID_W'(1);

    rr_pick u_pick_idle (
        .mask  (elig),
        .start (ptr_reg),
        .found (idle_found),
        .idx   (idle_idx)
    );

    rr_pick u_pick_next (
        .mask  (elig),
        .start (owner_inc),
        .found (next_found),
        .idx   (next_idx)
    );

    // read enable goes straight from req/out_ready to the owner's FIFO
    always_comb begin
        ren = '0;
        if ((state_reg == SERVE) && out_ready && req[owner_reg]) begin
            ren[owner_reg] = 1'b1;
        end
    end

    assign rd_fire     = |ren;
    // last credit consumed, or the owner's FIFO ran dry; frozen under backpressure
    assign release_now = (state_reg == SERVE) && out_ready &&
                         ((rd_fire && (credit_reg == WEIGHT_W'(1))) || !req[owner_reg]);

    assign gnt_valid = rd_fire;
    assign gnt_id    = owner_reg;
    assign busy      = (state_reg == SERVE);

    // ownership FSM: credit load on grant, decrement per read, hand-over on release
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            owner_reg  <= '0;
            credit_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (idle_found) begin
                        owner_reg  <= idle_idx;
                        credit_reg <= weight_eff[idle_idx];
                        state_reg  <= SERVE;
                    end
                end
                SERVE: begin
                    if (release_now) begin
                        ptr_reg <= owner_inc;
                        if (next_found) begin
                            owner_reg  <= next_idx;
                            credit_reg <= weight_eff[next_idx];
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (rd_fire) begin
                        credit_reg <= credit_reg - WEIGHT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_fifo_scheduler.sv
// Directed testbench for wrr_fifo_scheduler. Expected values are hand-derived
// for both builds (WRR_WEIGHTS_EN defined or not).
`timescale 1ns/1ps
module tb_wrr_fifo_scheduler;
    import wrr_pkg::*;

    logic                clk;
    logic                rst;
    logic [N_REQ-1:0]    req;
    logic                out_ready;
    logic                cfg_we;
    logic [ID_W-1:0]     cfg_id;
    logic [WEIGHT_W-1:0] cfg_weight;
    logic [N_REQ-1:0]    ren;
    logic [ID_W-1:0]     gnt_id;
    logic                gnt_valid;
    logic                busy;

    int checks;
    int errors;

    wrr_fifo_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .out_ready  (out_ready),
        .cfg_we     (cfg_we),
        .cfg_id     (cfg_id),
        .cfg_weight (cfg_weight),
        .ren        (ren),
        .gnt_id     (gnt_id),
        .gnt_valid  (gnt_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // move to just after the next rising edge
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; req = '0; out_ready = 1'b1; cfg_we = 1'b0; cfg_id = '0; cfg_weight = '0;
        adv();
        adv();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; out_ready = 1'b0; cfg_we = 1'b0; cfg_id = '0; cfg_weight = '0;
        adv();
        adv();
        #1;
        checks++;
        if (ren !== 4'b0000 || gnt_id !== 2'd0 || gnt_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ren=%b gnt_id=%0d gnt_valid=%b busy=%b required 0000/0/0/0",
                     ren, gnt_id, gnt_valid, busy);
        end
        req = 4'b1111; out_ready = 1'b1;
        adv();
        #1;
        checks++;
        if (ren !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: ren=%b busy=%b required 0000/0", ren, busy);
        end
    endtask

    task automatic test_plain_rr();
        logic [3:0] exp_ren [5];
        logic [1:0] exp_id  [5];
        exp_ren = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        reset_dut();
        req = 4'b1111; out_ready = 1'b1;
        #1;
        checks++;
        if (ren !== 4'b0000) begin
            errors++;
            $display("FAIL rr_latency: ren=%b required 0000", ren);
        end
        for (int i = 0; i < 5; i++) begin
            adv();
            #1;
            checks++;
            if (ren !== exp_ren[i] || gnt_id !== exp_id[i] || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_step%0d: ren=%b gnt_id=%0d gnt_valid=%b required %b/%0d/1",
                         i, ren, gnt_id, gnt_valid, exp_ren[i], exp_id[i]);
            end
        end
    endtask

    task automatic test_weighted_burst();
        logic [2:0] w [4];
        logic [3:0] exp_ren [10];
        w = '{3'd3, 3'd1, 3'd2, 3'd1};
`ifdef WRR_WEIGHTS_EN
        exp_ren = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100,
                    4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_ren = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                    4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`endif
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            cfg_we = 1'b1; cfg_id = 2'(k); cfg_weight = w[k];
            adv();
        end
        cfg_we = 1'b0;
        req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            adv();
            #1;
            checks++;
            if (ren !== exp_ren[i] || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrr_step%0d: ren=%b gnt_valid=%b required %b/1",
                         i, ren, gnt_valid, exp_ren[i]);
            end
        end
    endtask

    task automatic test_early_empty();
        logic [3:0] drv_req [4];
        logic [3:0] exp_ren [4];
        logic [1:0] exp_id  [4];
`ifdef WRR_WEIGHTS_EN
        drv_req = '{4'b0011, 4'b0011, 4'b0010, 4'b0010};
        exp_ren = '{4'b0001, 4'b0001, 4'b0000, 4'b0010};
        exp_id  = '{2'd0, 2'd0, 2'd0, 2'd1};
`else
        drv_req = '{4'b0011, 4'b0011, 4'b0011, 4'b0010};
        exp_ren = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        exp_id  = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
        reset_dut();
        cfg_we = 1'b1; cfg_id = 2'd0; cfg_weight = 3'd4;
        adv();
        cfg_we = 1'b0;
        req = 4'b0011; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            adv();
            req = drv_req[i];
            #1;
            checks++;
            if (ren !== exp_ren[i] || gnt_id !== exp_id[i]) begin
                errors++;
                $display("FAIL empty_step%0d: ren=%b gnt_id=%0d required %b/%0d",
                         i, ren, gnt_id, exp_ren[i], exp_id[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic       rdy     [6];
        logic [3:0] exp_ren [6];
        logic [1:0] exp_id  [6];
        rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef WRR_WEIGHTS_EN
        exp_ren = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b1000};
        exp_id  = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
`else
        exp_ren = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0100};
        exp_id  = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
`endif
        reset_dut();
        cfg_we = 1'b1; cfg_id = 2'd2; cfg_weight = 3'd2;
        adv();
        cfg_we = 1'b0;
        req = 4'b1100; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            adv();
            out_ready = rdy[i];
            #1;
            checks++;
            if (ren !== exp_ren[i] || gnt_id !== exp_id[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_step%0d: ren=%b gnt_id=%0d busy=%b required %b/%0d/1",
                         i, ren, gnt_id, busy, exp_ren[i], exp_id[i]);
            end
        end
    endtask

    task automatic test_weight0_and_reset();
        logic [3:0] exp_ren;
        logic       exp_busy;
`ifdef WRR_WEIGHTS_EN
        exp_ren = 4'b0000; exp_busy = 1'b0;
`else
        exp_ren = 4'b0010; exp_busy = 1'b1;
`endif
        reset_dut();
        cfg_we = 1'b1; cfg_id = 2'd1; cfg_weight = 3'd0; req = 4'b0000;
        adv();
        cfg_we = 1'b0; req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            adv();
            #1;
            checks++;
            if (ren !== exp_ren || busy !== exp_busy) begin
                errors++;
                $display("FAIL w0_step%0d: ren=%b busy=%b required %b/%b",
                         i, ren, busy, exp_ren, exp_busy);
            end
        end
        req = 4'b1111;
        adv();
        adv();
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy: busy=%b required 1", busy);
        end
        // reset mid-SERVE while also trying to zero weight[0]
        rst = 1'b1; cfg_we = 1'b1; cfg_id = 2'd0; cfg_weight = 3'd0;
        adv();
        #1;
        checks++;
        if (ren !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_serve: ren=%b busy=%b gnt_id=%0d gnt_valid=%b required 0000/0/0/0",
                     ren, busy, gnt_id, gnt_valid);
        end
        rst = 1'b0; cfg_we = 1'b0; req = 4'b1001;
        #1;
        checks++;
        if (ren !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_idle: ren=%b required 0000", ren);
        end
        adv();
        req = 4'b0010;
        #1;
        checks++;
        if (ren !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ptr: ren=%b gnt_id=%0d busy=%b required 0000/0/1",
                     ren, gnt_id, busy);
        end
        adv();
        #1;
        checks++;
        if (ren !== 4'b0010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_weight: ren=%b gnt_id=%0d required 0010/1", ren, gnt_id);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_plain_rr();
        test_weighted_burst();
        test_early_empty();
        test_backpressure();
        test_weight0_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
